// File: rtl/det2_seq.sv
// det2_seq: sequential 2x2 determinant (a*d - b*c) on unsigned W-bit operands.
// The result is sign-magnitude. Two shift-add multipliers run in parallel,
// one operand bit per cycle. Operands enter and results leave through
// valid/ready handshakes.
module det2_seq #(
   parameter int W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     a,
   input  logic [W-1:0]     b,
   input  logic [W-1:0]     c,
   input  logic [W-1:0]     d,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2*W-1:0]   mag,
   output logic             sign,
   output logic             zero
);

   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(W - 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [2*W-1:0] MAG_ONE  = (2*W)'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_SUB  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     c_q, c_d;
   logic [W-1:0]     d_q, d_d;
   logic [2*W-1:0]   p_q, p_d;
   logic [2*W-1:0]   q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2*W-1:0]   mag_q, mag_d;
   logic             sign_q, sign_d;
   logic             zero_q, zero_d;

   // Operands zero-extended to product width so they can be shifted into place.
   logic [2*W-1:0]   a_ext;
   logic [2*W-1:0]   b_ext;
   // One extra bit on the difference carries the borrow, i.e. the sign.
   logic [2*W:0]     diff;

   assign a_ext = {{W{1'b0}}, a_q};
   assign b_ext = {{W{1'b0}}, b_q};
   assign diff  = {1'b0, p_q} - {1'b0, q_q};

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign mag       = mag_q;
   assign sign      = sign_q;
   assign zero      = zero_q;

   // Next-state and datapath: accept, accumulate partial products, then subtract.
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      d_d     = d_q;
      p_d     = p_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      mag_d   = mag_q;
      sign_d  = sign_q;
      zero_d  = zero_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               a_d     = a;
               b_d     = b;
               c_d     = c;
               d_d     = d;
               p_d     = '0;
               q_d     = '0;
               cnt_d   = '0;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            // Bit cnt of d selects a shifted copy of a; bit cnt of c does the same for b.
            if (d_q[cnt_q]) begin
               p_d = p_q + (a_ext << cnt_q);
            end
            if (c_q[cnt_q]) begin
               q_d = q_q + (b_ext << cnt_q);
            end
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
               state_d = S_SUB;
            end
         end
         S_SUB: begin
            sign_d  = diff[2*W];
            mag_d   = diff[2*W] ? (~diff[2*W-1:0] + MAG_ONE) : diff[2*W-1:0];
            zero_d  = (p_q == q_q);
            state_d = S_DONE;
         end
         S_DONE: begin
            // Result registers are left alone so they stay valid after the handshake.
            if (out_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset abandons any computation in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         d_q     <= '0;
         p_q     <= '0;
         q_q     <= '0;
         cnt_q   <= '0;
         mag_q   <= '0;
         sign_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         d_q     <= d_d;
         p_q     <= p_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         mag_q   <= mag_d;
         sign_q  <= sign_d;
         zero_q  <= zero_d;
      end
   end

endmodule

// File: tb/tb_det2_seq.sv
// tb_det2_seq: randomized and directed checks of det2_seq at W=4 and W=8
// against an arithmetic reference (a*d - b*c computed directly).
module tb_det2_seq;

   logic        clk;
   logic        rst;

   // W=4 instance signals
   logic        in_valid4, in_ready4, out_valid4, out_ready4;
   logic [3:0]  a4, b4, c4, d4;
   logic [7:0]  mag4;
   logic        sign4, zero4;

   // W=8 instance signals
   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8, c8, d8;
   logic [15:0] mag8;
   logic        sign8, zero8;

   int n_checks;
   int n_pass;
   int cyc;
   int last_acc;

   det2_seq #(.W(4)) dut4 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid4), .in_ready(in_ready4),
      .a(a4), .b(b4), .c(c4), .d(d4),
      .out_valid(out_valid4), .out_ready(out_ready4),
      .mag(mag4), .sign(sign4), .zero(zero4)
   );

   det2_seq #(.W(8)) dut8 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .c(c8), .d(d8),
      .out_valid(out_valid8), .out_ready(out_ready8),
      .mag(mag8), .sign(sign8), .zero(zero8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Reference model: plain signed arithmetic on the matrix elements.
   function automatic longint ref_det(input int ia, input int ib, input int ic, input int id);
      return longint'(ia) * longint'(id) - longint'(ib) * longint'(ic);
   endfunction

   // One W=4 transaction with `hold` cycles of downstream backpressure.
   task automatic run4(input int ia, input int ib, input int ic, input int id, input int hold);
      longint det;
      longint emag;
      int     lat;
      logic [7:0] held_mag;
      det  = ref_det(ia, ib, ic, id);
      emag = (det < 0) ? -det : det;
      @(negedge clk);
      a4 = 4'(ia); b4 = 4'(ib); c4 = 4'(ic); d4 = 4'(id);
      in_valid4  = 1'b1;
      out_ready4 = 1'b0;
      chk("in_ready_idle", in_ready4, 1);
      @(posedge clk);
      #1;
      // Scramble the inputs after the accept edge; they must be ignored.
      in_valid4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); c4 = 4'($urandom); d4 = 4'($urandom);
      lat = 0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk);
         #1;
         if (out_valid4) begin
            lat = i;
            break;
         end
         if (in_ready4 !== 1'b0) chk("in_ready_busy", in_ready4, 0);
      end
      chk("latency", lat, 5);
      chk("mag", mag4, emag);
      chk("sign", sign4, (det < 0) ? 1 : 0);
      chk("zero", zero4, (det == 0) ? 1 : 0);
      $display("txn W=4 a=%0d b=%0d c=%0d d=%0d -> mag=%0d sign=%0d zero=%0d lat=%0d hold=%0d",
               ia, ib, ic, id, mag4, sign4, zero4, lat, hold);
      held_mag = mag4;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk);
         #1;
         chk("bp_out_valid", out_valid4, 1);
         chk("bp_in_ready", in_ready4, 0);
         chk("bp_mag", mag4, emag);
      end
      out_ready4 = 1'b1;
      @(posedge clk);
      #1;
      out_ready4 = 1'b0;
      chk("post_out_valid", out_valid4, 0);
      chk("post_in_ready", in_ready4, 1);
      chk("post_mag_retained", mag4, {56'd0, held_mag});
   endtask

   // One W=8 back-to-back transaction; in_valid8 and out_ready8 stay high.
   task automatic run8(input int ia, input int ib, input int ic, input int id, input int idx);
      longint det;
      longint emag;
      bit     ok;
      int     acc;
      det  = ref_det(ia, ib, ic, id);
      emag = (det < 0) ? -det : det;
      a8 = 8'(ia); b8 = 8'(ib); c8 = 8'(ic); d8 = 8'(id);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (in_ready8) begin
            ok = 1'b1;
            break;
         end
      end
      chk("b2b_ready_seen", ok, 1);
      @(posedge clk);
      #1;
      acc = cyc;
      if (idx > 0) chk("b2b_spacing", acc - last_acc, 11);
      last_acc = acc;
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (out_valid8) begin
            ok = 1'b1;
            break;
         end
      end
      chk("b2b_out_seen", ok, 1);
      chk("b2b_mag", mag8, emag);
      chk("b2b_sign", sign8, (det < 0) ? 1 : 0);
      chk("b2b_zero", zero8, (det == 0) ? 1 : 0);
      $display("txn W=8 a=%0d b=%0d c=%0d d=%0d -> mag=%0d sign=%0d zero=%0d accept_cyc=%0d",
               ia, ib, ic, id, mag8, sign8, zero8, acc);
   endtask

   initial begin
      n_checks   = 0;
      n_pass     = 0;
      cyc        = 0;
      last_acc   = 0;
      rst        = 1'b1;
      in_valid4  = 1'b0; out_ready4 = 1'b0;
      a4 = '0; b4 = '0; c4 = '0; d4 = '0;
      in_valid8  = 1'b0; out_ready8 = 1'b0;
      a8 = '0; b8 = '0; c8 = '0; d8 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Reset state
      chk("rst_mag", mag4, 0);
      chk("rst_sign", sign4, 0);
      chk("rst_zero", zero4, 0);
      chk("rst_out_valid", out_valid4, 0);
      chk("rst_in_ready", in_ready4, 1);
      chk("rst_mag8", mag8, 0);

      // Directed cases
      run4(15, 1, 1, 15, 0);
      run4(1, 15, 15, 1, 1);
      run4(3, 2, 6, 4, 0);
      run4(5, 2, 3, 7, 10);
      run4(15, 15, 15, 15, 0);
      run4(0, 0, 0, 0, 0);
      run4(0, 15, 15, 0, 2);

      // Reset two cycles into MUL
      @(negedge clk);
      a4 = 4'd9; b4 = 4'd1; c4 = 4'd2; d4 = 4'd7;
      in_valid4 = 1'b1;
      @(posedge clk);
      #1;
      in_valid4 = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      #2;
      chk("midrst_out_valid", out_valid4, 0);
      chk("midrst_mag", mag4, 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst_in_ready", in_ready4, 1);
      for (int i = 0; i < 8; i++) begin
         @(posedge clk);
         #1;
         if (out_valid4 !== 1'b0) chk("midrst_no_result", out_valid4, 0);
      end
      run4(2, 1, 1, 2, 0);

      // Randomized W=4 transactions
      for (int t = 0; t < 25; t++) begin
         run4($urandom_range(0, 15), $urandom_range(0, 15),
              $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
      end

      // W=8 back-to-back
      @(negedge clk);
      out_ready8 = 1'b1;
      in_valid8  = 1'b1;
      run8(255, 0, 0, 255, 0);
      run8(0, 255, 255, 0, 1);
      for (int t = 2; t < 8; t++) begin
         run8($urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 255), t);
      end
      @(negedge clk);
      in_valid8 = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
